// File: rtl/muldiv_pkg.sv
// Shared constants for the iterative multiply/divide unit: operation codes,
// FSM state encodings and the number of iterations per operation.
package muldiv_pkg;

  localparam logic [1:0] OP_MULL = 2'b00;
  localparam logic [1:0] OP_MULH = 2'b01;
  localparam logic [1:0] OP_DIVU = 2'b10;
  localparam logic [1:0] OP_REMU = 2'b11;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_FIN  = 2'd2;

  localparam int STEPS = 32;

  // Divide and remainder share the restoring datapath; bit 1 of the opcode selects it.
  function automatic logic op_is_div(input logic [1:0] op);
    return op[1];
  endfunction

endpackage

// File: rtl/muldiv_paso.sv
// One combinational iteration: shift-add multiply step or restoring divide step
// on the 64-bit accumulator ({product high, low} or {remainder, quotient}).
module muldiv_paso #(
  parameter int WIDTH = 32
) (
  input  logic [2*WIDTH-1:0] acc_in,
  input  logic [WIDTH-1:0]   operand,
  input  logic               is_div,
  output logic [2*WIDTH-1:0] acc_out
);

  logic [WIDTH-1:0]   hi;
  logic [WIDTH-1:0]   lo;
  logic [WIDTH:0]     sum;
  logic [WIDTH:0]     rem_sh;
  logic [WIDTH-1:0]   diff;
  logic               geq;
  logic [2*WIDTH-1:0] mul_next;
  logic [2*WIDTH-1:0] div_next;

  assign hi = acc_in[2*WIDTH-1:WIDTH];
  assign lo = acc_in[WIDTH-1:0];

  // The adder carry becomes bit 63 after the right shift.
  assign sum      = {1'b0, hi} + {1'b0, (lo[0] ? operand : {WIDTH{1'b0}})};
  assign mul_next = {sum, lo[WIDTH-1:1]};

  // The shifted remainder needs 33 bits; when it is >= B the difference fits in 32.
  assign rem_sh   = {hi, lo[WIDTH-1]};
  assign geq      = rem_sh >= {1'b0, operand};
  assign diff     = rem_sh[WIDTH-1:0] - operand;
  assign div_next = geq ? {diff, lo[WIDTH-2:0], 1'b1}
                        : {rem_sh[WIDTH-1:0], lo[WIDTH-2:0], 1'b0};

  assign acc_out = is_div ? div_next : mul_next;

endmodule

// File: rtl/unidad_mul_div.sv
// Iterative unsigned multiply/divide unit between the register bank read ports
// and its write port; 32 iterations per operation, one-cycle write strobe at the end.
module unidad_mul_div
  import muldiv_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 5
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              START_MD,
  input  logic [1:0]        OP_MD,
  input  logic [WIDTH-1:0]  A_MD,
  input  logic [WIDTH-1:0]  B_MD,
  input  logic [ADDR_W-1:0] WA_IN_MD,
  output logic              BUSY_MD,
  output logic              DONE_MD,
  output logic [WIDTH-1:0]  DW_MD,
  output logic [ADDR_W-1:0] WA_MD,
  output logic              WE_MD
);

  logic [1:0]         state;
  logic [5:0]         cnt;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_next;
  logic [WIDTH-1:0]   b_q;
  logic [1:0]         op_q;
  logic [ADDR_W-1:0]  wa_q;
  logic [WIDTH-1:0]   result;

  muldiv_paso #(.WIDTH(WIDTH)) u_paso (
    .acc_in  (acc),
    .operand (b_q),
    .is_div  (op_is_div(op_q)),
    .acc_out (acc_next)
  );

  // Result is taken from the accumulator produced by the final iteration.
  always_comb begin
    result = acc_next[WIDTH-1:0];
    case (op_q)
      OP_MULL: result = acc_next[WIDTH-1:0];
      OP_MULH: result = acc_next[2*WIDTH-1:WIDTH];
      OP_DIVU: result = acc_next[WIDTH-1:0];
      OP_REMU: result = acc_next[2*WIDTH-1:WIDTH];
      default: result = acc_next[WIDTH-1:0];
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      acc     <= '0;
      b_q     <= '0;
      op_q    <= OP_MULL;
      wa_q    <= '0;
      BUSY_MD <= 1'b0;
      DONE_MD <= 1'b0;
      WE_MD   <= 1'b0;
      DW_MD   <= '0;
      WA_MD   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (START_MD) begin
            // Dividend/multiplier enters the low half and is shifted out as it is consumed.
            acc     <= {{WIDTH{1'b0}}, A_MD};
            b_q     <= B_MD;
            op_q    <= OP_MD;
            wa_q    <= WA_IN_MD;
            cnt     <= '0;
            BUSY_MD <= 1'b1;
            state   <= ST_CALC;
          end
        end
        ST_CALC: begin
          acc <= acc_next;
          cnt <= cnt + 6'd1;
          if (cnt == 6'(STEPS - 1)) begin
            DW_MD   <= result;
            WA_MD   <= wa_q;
            DONE_MD <= 1'b1;
            WE_MD   <= (wa_q != '0);
            state   <= ST_FIN;
          end
        end
        ST_FIN: begin
          DONE_MD <= 1'b0;
          WE_MD   <= 1'b0;
          BUSY_MD <= 1'b0;
          state   <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
